// File: rtl/if_id_pkg.sv
// Shared fetch/decode types and defaults for the IF/ID instruction queue.
package if_id_pkg;
  localparam int          PC_W_DEF      = 16;
  localparam int          INSTR_W_DEF   = 16;
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x W register array: synchronous write, asynchronous read.
module sync_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry IF/ID instruction queue with NOP bubble when empty and flush.
// Define IF_ID_QUEUE_BYPASS_EN for a same-cycle empty-queue bypass path.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int               INSTR_W   = INSTR_W_DEF,
  parameter int               PC_W      = PC_W_DEF,
  parameter int               DEPTH     = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int               PC_INC    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            pc_in,
  input  logic [INSTR_W-1:0]         instr_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            pc_out,
  output logic [INSTR_W-1:0]         instr_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = PC_W + INSTR_W;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic [PC_W-1:0] pc_inc;
  logic [EW-1:0] head;
  logic not_empty, push, mem_push, mem_pop, byp, byp_take;

  assign pc_inc    = pc_in + PC_W'(PC_INC);
  assign not_empty = (cnt != '0);
  assign in_ready  = !rst && !flush && (cnt != CW'(DEPTH));
  assign push      = in_valid && in_ready;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign byp = !not_empty && in_valid && !flush && !rst;
`else
  assign byp = 1'b0;
`endif
  // A bypassed entry consumed in the same cycle never touches the array.
  assign byp_take = byp && out_ready;
  assign mem_push = push && !byp_take;
  assign mem_pop  = not_empty && out_ready;

  sync_fifo_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .clk   (clk),
    .we    (mem_push),
    .waddr (wr_ptr),
    .wdata ({pc_inc, instr_in}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (mem_push) wr_ptr <= wr_ptr + 1'b1;
      if (mem_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({mem_push, mem_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    out_valid = not_empty || byp;
    pc_out    = '0;
    instr_out = NOP_INSTR;
    if (not_empty) begin
      pc_out    = head[EW-1:INSTR_W];
      instr_out = head[INSTR_W-1:0];
    end else if (byp) begin
      pc_out    = pc_inc;
      instr_out = instr_in;
    end
  end

  assign count = cnt;
endmodule

// File: tb/tb_if_id_queue.sv
// Randomized + directed bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
  import if_id_pkg::*;

  localparam int DEPTH = 4;
`ifdef IF_ID_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] pc_in, instr_in, pc_out, instr_out;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;
  fetch_entry_t model_q[$];

  always #5 clk = ~clk;

  if_id_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in), .instr_in(instr_in),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .instr_out(instr_out),
    .count(count)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Reference: the queue contents themselves are the architectural state.
  always @(posedge clk) begin
    if (rst || flush) model_q.delete();
    else begin
      automatic bit full  = (model_q.size() == DEPTH);
      automatic bit bpass = BYP && (model_q.size() == 0) && in_valid;
      automatic fetch_entry_t e;
      e.pc    = pc_in + 16'd1;
      e.instr = instr_in;
      if (model_q.size() > 0 && out_ready) void'(model_q.pop_front());
      if (in_valid && !full && !(bpass && out_ready)) model_q.push_back(e);
    end
  end

  // Monitor: compares every DUT output mid-cycle against the model.
  always @(negedge clk) if (armed) begin
    automatic bit bpass = BYP && (model_q.size() == 0) && in_valid && !flush && !rst;
    automatic bit ev = (model_q.size() > 0) || bpass;
    automatic logic [15:0] epc = 16'h0000, eins = NOP_INSTR_DEF;
    if (model_q.size() > 0) begin
      epc = model_q[0].pc; eins = model_q[0].instr;
    end else if (bpass) begin
      epc = pc_in + 16'd1; eins = instr_in;
    end
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("count",     32'(count),     32'(model_q.size()));
    chk("in_ready",  32'(in_ready),  32'(!rst && !flush && model_q.size() != DEPTH));
    chk("pc_out",    32'(pc_out),    32'(epc));
    chk("instr_out", 32'(instr_out), 32'(eins));
  end

  task automatic step(input logic r, input logic fl, input logic iv,
                      input logic [15:0] pc, input logic [15:0] ins, input logic ordy);
    rst = r; flush = fl; in_valid = iv; pc_in = pc; instr_in = ins; out_ready = ordy;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset held two cycles with an offer present
    step(1, 0, 1, 16'h1234, 16'hAAAA, 0);
    armed = 1'b1;
    step(1, 0, 1, 16'h1234, 16'hAAAA, 0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'h0800);

    // Fill to full, offer once more while full, then drain to the bubble
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0010 + 16'(i), 16'h0100 + 16'(i), 0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    step(0, 0, 1, 16'h00EE, 16'hDEAD, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0, 16'h0, 1);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Steady push+pop at count 2, pointers wrap
    for (int i = 0; i < 2; i++) step(0, 0, 1, 16'h0030 + 16'(i), 16'h0200 + 16'(i), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 16'h0040 + 16'(i), 16'h0300 + 16'(i), 1);
    chk("pp_count", 32'(count), 32'd2);

    // Reach count 3, then flush with an offer present
    step(0, 0, 1, 16'h0050, 16'h0400, 0);
    step(0, 1, 1, 16'h0051, 16'h0401, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_instr", 32'(instr_out), 32'h0800);

    // PC wrap
    step(0, 0, 1, 16'hFFFF, 16'h0500, 0);
    chk("wrap_pc", 32'(pc_out), 32'h0000);
    step(0, 0, 0, 16'h0, 16'h0, 1);

    // Empty queue offer with decode ready (same-cycle result depends on bypass build)
    rst = 0; flush = 0; in_valid = 1; pc_in = 16'h0020; instr_in = 16'h0600; out_ready = 1;
    #2;
    chk("byp_valid", 32'(out_valid), 32'(BYP));
    chk("byp_pc", 32'(pc_out), BYP ? 32'h0021 : 32'h0000);
    @(posedge clk); #1;
    step(0, 0, 0, 16'h0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 16'h0, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(199) == 0, $urandom_range(39) == 0, $urandom_range(9) < 7,
           16'($urandom), 16'($urandom), $urandom_range(9) < 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
